// File: rtl/fifo_pkt_reader_pkg.sv
// Shared constants and FSM encoding for the packet FIFO read side.
package fifo_pkt_reader_pkg;
  localparam int FIFO_WIDTH = 9;
  localparam int LAST_BIT   = FIFO_WIDTH - 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_GAP    = 2'd2;
endpackage

// File: rtl/fifo_pkt_reader_if.sv
// FIFO head pins plus downstream valid/ready stream; master is the reader.
interface fifo_pkt_reader_if #(parameter int WIDTH = 9);
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [WIDTH-2:0] out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (input fifo_data, fifo_empty, out_ready,
                  output fifo_rd, out_data, out_last, out_valid);
  modport slave  (output fifo_data, fifo_empty, out_ready,
                  input fifo_rd, out_data, out_last, out_valid);
endinterface

// File: rtl/fifo_pkt_reader_rd_out_reg.sv
// Single-entry output register: loads on pop, holds data while stalled.
module rd_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstp,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_valid
);
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;

  // load is only raised when the slot is empty or draining this cycle
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = in_data;
      last_d  = in_last;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
endmodule

// File: rtl/fifo_pkt_reader.sv
// Packet FIFO reader: FSM (IDLE/STREAM/GAP), inter-packet gap and length count.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int GAP_CYCLES = 2,
  parameter int LEN_W      = 8
) (
  input  logic               clk,
  input  logic               rstp,
  input  logic               enable,
  fifo_pkt_reader_if.master  bus,
  output logic               pkt_done,
  output logic [LEN_W-1:0]   pkt_len,
  output logic               len_err,
  output logic               busy
);
  localparam int LB    = WIDTH - 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             len_err_q, len_err_d;
  logic             pkt_done_q, pkt_done_d;

  logic             pop, pop_last, hs;
  logic [LEN_W-1:0] cnt_inc;

  assign pop      = (state_q == ST_STREAM) && !bus.fifo_empty &&
                    (!bus.out_valid || bus.out_ready);
  assign pop_last = pop && bus.fifo_data[LB];
  assign hs       = bus.out_valid && bus.out_ready;
  assign cnt_inc  = (cnt_q == LEN_MAX) ? LEN_MAX : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    pkt_len_d  = pkt_len_q;
    len_err_d  = len_err_q;
    pkt_done_d = hs && bus.out_last;
    case (state_q)
      ST_IDLE:
        if (enable && !bus.fifo_empty) state_d = ST_STREAM;
      ST_STREAM:
        if (pop_last) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      ST_GAP: begin
        // last gap cycle is the one where the counter is about to hit zero
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAP_ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (hs) begin
      if (cnt_inc == LEN_MAX) len_err_d = 1'b1;
      if (bus.out_last) begin
        pkt_len_d = cnt_inc;
        cnt_d     = '0;
      end else begin
        cnt_d     = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      cnt_q      <= '0;
      pkt_len_q  <= '0;
      len_err_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      pkt_len_q  <= pkt_len_d;
      len_err_q  <= len_err_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  rd_out_reg #(.DW(WIDTH - 1)) u_out (
    .clk       (clk),
    .rstp      (rstp),
    .load      (pop),
    .in_data   (bus.fifo_data[LB-1:0]),
    .in_last   (bus.fifo_data[LB]),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last),
    .out_valid (bus.out_valid)
  );

  assign bus.fifo_rd = pop;
  assign pkt_done    = pkt_done_q;
  assign pkt_len     = pkt_len_q;
  assign len_err     = len_err_q;
  assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench: FIFO model + stream monitor around two reader configurations.
module tb_fifo_pkt_reader;
  logic clk = 1'b0;
  logic rstp;
  logic en;
  logic rdy, tog, ph;

  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.WIDTH(9)) ifa ();
  fifo_pkt_reader_if #(.WIDTH(9)) ifb ();

  logic       done_a, err_a, busy_a;
  logic [7:0] len_a;
  logic       done_b, err_b, busy_b;
  logic [1:0] len_b;

  fifo_pkt_reader #(.WIDTH(9), .GAP_CYCLES(2), .LEN_W(8)) dut_a (
    .clk(clk), .rstp(rstp), .enable(en), .bus(ifa),
    .pkt_done(done_a), .pkt_len(len_a), .len_err(err_a), .busy(busy_a)
  );

  fifo_pkt_reader #(.WIDTH(9), .GAP_CYCLES(0), .LEN_W(2)) dut_b (
    .clk(clk), .rstp(rstp), .enable(en), .bus(ifb),
    .pkt_done(done_b), .pkt_len(len_b), .len_err(err_b), .busy(busy_b)
  );

  // FIFO models: first-word-fall-through, never reset by the reader
  logic [8:0]  mem_a [0:63];
  logic [8:0]  mem_b [0:63];
  int unsigned wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

  assign ifa.fifo_empty = (wr_a == rd_a);
  assign ifa.fifo_data  = mem_a[rd_a[5:0]];
  assign ifb.fifo_empty = (wr_b == rd_b);
  assign ifb.fifo_data  = mem_b[rd_b[5:0]];
  assign ifa.out_ready  = tog ? ph : rdy;
  assign ifb.out_ready  = 1'b1;

  always @(posedge clk) begin
    if (ifa.fifo_rd) rd_a <= rd_a + 1;
    if (ifb.fifo_rd) rd_b <= rd_b + 1;
  end

  always @(negedge clk) ph <= ~ph;

  logic [8:0] obs_a [$];
  int         viol_rd = 0, viol_st = 0, cnt_done = 0;
  logic       hold = 1'b0;
  logic [8:0] held;

  always @(posedge clk) begin
    if (ifa.out_valid && ifa.out_ready) obs_a.push_back({ifa.out_last, ifa.out_data});
    if (ifa.fifo_rd && ifa.out_valid && !ifa.out_ready) viol_rd++;
    if (hold && ifa.out_valid && ({ifa.out_last, ifa.out_data} != held)) viol_st++;
    hold = ifa.out_valid && !ifa.out_ready;
    held = {ifa.out_last, ifa.out_data};
    if (done_a) cnt_done++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [8:0] exp);
    logic [8:0] w;
    if (obs_a.size() == 0) begin
      chk(tag, -1, int'(exp));
    end else begin
      w = obs_a.pop_front();
      chk(tag, int'(w), int'(exp));
    end
  endtask

  task automatic push_a(input logic [8:0] w);
    mem_a[wr_a[5:0]] = w;
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [8:0] w);
    mem_b[wr_b[5:0]] = w;
    wr_b = wr_b + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  pat;
    int unsigned rd_snap;
    rstp = 1'b1; en = 1'b1; rdy = 1'b1; tog = 1'b0; ph = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_data",  ifa.out_data, 0);
    chk("rst_last",  ifa.out_last, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_len",   len_a, 0);
    chk("rst_err",   err_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_rd",    ifa.fifo_rd, 0);
    rstp = 1'b0;
    @(negedge clk);

    // basic packet followed by a 1-word packet; check pop pattern around the gap
    push_a(9'h001); push_a(9'h002); push_a(9'h103); push_a(9'h104);
    pat = '0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      pat = {pat[5:0], ifa.fifo_rd};
      if (i == 2) chk("first_lat", ifa.out_valid, 1);
      if (i == 5) begin
        chk("p1_done", done_a, 1);
        chk("p1_len",  len_a, 3);
      end
    end
    chk("rd_gap_pat", pat, 7'b1110001);
    repeat (6) @(negedge clk);
    chk_word("p1_w0", 9'h001);
    chk_word("p1_w1", 9'h002);
    chk_word("p1_w2", 9'h103);
    chk_word("p2_w0", 9'h104);
    chk("done_pulses", cnt_done, 2);
    chk("p2_len", len_a, 1);

    // ready toggling every cycle
    tog = 1'b1;
    push_a(9'h001); push_a(9'h002); push_a(9'h103);
    repeat (20) @(negedge clk);
    tog = 1'b0;
    chk_word("tg_w0", 9'h001);
    chk_word("tg_w1", 9'h002);
    chk_word("tg_w2", 9'h103);
    chk("tg_extra", obs_a.size(), 0);
    chk("tg_rd_full", viol_rd, 0);
    chk("tg_stable", viol_st, 0);
    chk("tg_len", len_a, 3);

    // enable dropped mid-packet
    push_a(9'h011); push_a(9'h012); push_a(9'h113); push_a(9'h021); push_a(9'h122);
    @(negedge clk);
    en = 1'b0;
    repeat (12) @(negedge clk);
    chk_word("en_w0", 9'h011);
    chk_word("en_w1", 9'h012);
    chk_word("en_w2", 9'h113);
    chk("en_len", len_a, 3);
    chk("en_left", int'(wr_a - rd_a), 2);
    chk("en_busy", busy_a, 0);
    en = 1'b1;
    repeat (8) @(negedge clk);
    chk_word("en2_w0", 9'h021);
    chk_word("en2_w1", 9'h122);
    chk("en2_len", len_a, 2);

    // FIFO runs dry mid-packet
    push_a(9'h051);
    repeat (4) @(negedge clk);
    chk("dry_busy", busy_a, 1);
    chk("dry_valid", ifa.out_valid, 0);
    chk("dry_rd", ifa.fifo_rd, 0);
    repeat (4) @(negedge clk);
    push_a(9'h152);
    repeat (4) @(negedge clk);
    chk_word("dry_w0", 9'h051);
    chk_word("dry_w1", 9'h152);
    chk("dry_len", len_a, 2);
    repeat (4) @(negedge clk);

    // length saturation on the narrow-counter instance
    chk("sat_err0", err_b, 0);
    push_b(9'h031); push_b(9'h032); push_b(9'h033); push_b(9'h034); push_b(9'h135);
    repeat (12) @(negedge clk);
    chk("sat_len", len_b, 3);
    chk("sat_err", err_b, 1);
    push_b(9'h041); push_b(9'h142);
    repeat (8) @(negedge clk);
    chk("sat_len2", len_b, 2);
    chk("sat_err2", err_b, 1);

    // reset while a word is held in the output register
    obs_a.delete();
    push_a(9'h061); push_a(9'h062); push_a(9'h163);
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    chk("mr_valid", ifa.out_valid, 1);
    chk("mr_data", ifa.out_data, 8'h62);
    rd_snap = rd_a;
    rstp = 1'b1;
    #1;
    chk("mr_rst_valid", ifa.out_valid, 0);
    chk("mr_rst_data", ifa.out_data, 0);
    chk("mr_rst_len", len_a, 0);
    chk("mr_rst_busy", busy_a, 0);
    chk("mr_rst_rd", ifa.fifo_rd, 0);
    @(negedge clk);
    chk("mr_fifo_kept", int'(rd_a), int'(rd_snap));
    rstp = 1'b0;
    rdy = 1'b1;
    repeat (10) @(negedge clk);
    chk_word("mr_w0", 9'h061);
    chk_word("mr_w1", 9'h163);
    chk("mr_extra", obs_a.size(), 0);
    chk("mr_len", len_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
